// File: rtl/mod_sequencer.sv
// Multi-cycle modulus/quotient sequencer.
// Computes A mod B and A / B by repeated subtraction through the external ALU.
// Each iteration is one compare cycle (set-less-than) and one subtract cycle.
// The ALU result is consumed in the same cycle it is produced.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; ALU driven with zeros
// CMP   | ALU computes R < Bq; a set bit 0 means the division is finished
// SUB   | ALU computes R - Bq; result becomes the new R, Q increments
// DONE  | one-cycle done pulse; results are valid and held
module mod_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] bq_q, bq_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             err_q, err_d;
  logic             bad_operands;

  // The ALU compare is signed, so any operand with its MSB set is rejected.
  assign bad_operands = (divisor == '0) || dividend[WIDTH-1] || divisor[WIDTH-1];

  // State, working registers and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      bq_q    <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      bq_q    <= bq_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    bq_d    = bq_q;
    q_d     = q_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_operands) begin
            err_d   = 1'b1;
            rem_d   = '0;
            quo_d   = '0;
            state_d = S_DONE;
          end else begin
            r_d     = dividend;
            bq_d    = divisor;
            q_d     = '0;
            err_d   = 1'b0;
            state_d = S_CMP;
          end
        end
      end
      S_CMP: begin
        if (alu_result[0]) begin
          rem_d   = r_q;
          quo_d   = q_q;
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        r_d     = alu_result;
        q_d     = q_q + 1'b1;
        state_d = S_CMP;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive and status flags decoded from the current state.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_NOP;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      S_CMP: begin
        alu_a  = r_q;
        alu_b  = bq_q;
        alu_op = OP_SLT;
        busy   = 1'b1;
      end
      S_SUB: begin
        alu_a  = r_q;
        alu_b  = bq_q;
        alu_op = OP_SUB;
        busy   = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign remainder = rem_q;
  assign quotient  = quo_q;
  assign error     = err_q;

endmodule

// File: tb/tb_mod_sequencer.sv
// Self-checking bench for mod_sequencer: directed cases plus randomized operands,
// compared against an arithmetic reference (a / b, a % b, 2q+2 latency).
module tb_mod_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         busy, done, error;
  logic [W-1:0] remainder, quotient;

  int n_tests;
  int n_fail;

  mod_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .remainder  (remainder),
    .quotient   (quotient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: signed set-less-than and subtract.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b100:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'b110:  alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation starting now (cycle 0). If ign_cyc > 0, a start with
  // operands (a2,b2) is pulsed in that cycle and must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int ign_cyc, input logic [W-1:0] a2, input logic [W-1:0] b2);
    logic         exp_err;
    logic [W-1:0] exp_q, exp_r, exp_a;
    int           done_cyc;
    logic [2:0]   exp_op;
    exp_err = (b == 0) || a[W-1] || b[W-1];
    exp_q   = exp_err ? '0 : a / b;
    exp_r   = exp_err ? '0 : a % b;
    done_cyc = exp_err ? 1 : 2 * int'(exp_q) + 2;

    start    = 1'b1;
    dividend = a;
    divisor  = b;
    for (int k = 1; k <= done_cyc; k++) begin
      step();
      start    = (k == ign_cyc);
      dividend = (k == ign_cyc) ? a2 : $urandom;
      divisor  = (k == ign_cyc) ? b2 : $urandom;
      if (k < done_cyc) begin
        exp_op = (k % 2 == 1) ? 3'b100 : 3'b110;
        exp_a  = a - W'((k - 1) / 2) * b;
        check($sformatf("busy_cyc%0d_%0d/%0d", k, a, b),
              {busy, done, alu_op, alu_a, alu_b}, {1'b1, 1'b0, exp_op, exp_a, b});
      end else begin
        check($sformatf("done_cyc%0d_%0d/%0d", k, a, b),
              {busy, done, alu_op, alu_a, alu_b}, {1'b0, 1'b1, 3'b000, 32'd0, 32'd0});
        check($sformatf("result_%0d/%0d", a, b),
              {error, remainder, quotient}, {exp_err, exp_r, exp_q});
      end
    end
    start = 1'b0;
    step();
    check($sformatf("held_%0d/%0d", a, b),
          {busy, done, error, remainder, quotient}, {1'b0, 1'b0, exp_err, exp_r, exp_q});
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset_state", {busy, done, error, alu_op, alu_a, alu_b, remainder, quotient}, '0);
    rst_n = 1'b1;
    step();

    run_op(32'd17, 32'd5, 0, 0, 0);
    run_op(32'd4, 32'd9, 0, 0, 0);
    run_op(32'd20, 32'd5, 0, 0, 0);
    run_op(32'd7, 32'd0, 0, 0, 0);
    run_op(32'h8000_0000, 32'd3, 0, 0, 0);
    run_op(32'd5, 32'h8000_0001, 0, 0, 0);
    run_op(32'd17, 32'd5, 3, 32'd100, 32'd7);
    run_op(32'd3, 32'd3, 0, 0, 0);

    // Asynchronous reset in the middle of cycle 4 (a SUB cycle) of 17 mod 5.
    start    = 1'b1;
    dividend = 32'd17;
    divisor  = 32'd5;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("pre_reset_sub", {busy, alu_op, alu_a}, {1'b1, 3'b110, 32'd12});
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear",
          {busy, done, error, alu_op, alu_a, alu_b, remainder, quotient}, '0);
    step();
    step();
    check("reset_held_no_done", {busy, done}, 2'b00);
    rst_n = 1'b1;
    step();
    run_op(32'd9, 32'd4, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom_range(0, 300);
      rb = $urandom_range(1, 40);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: ra = ra | 32'h8000_0000;
        2: rb = rb | 32'h8000_0000;
        default: ;
      endcase
      run_op(ra, rb, ($urandom_range(0, 3) == 0) ? 2 : 0, $urandom_range(0, 50), $urandom_range(1, 9));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
